// File: rtl/pkt_to_msg_if.sv
// Flit-side and message-side signals of the packet-to-message reassembler.
// The slave modport is the reassembler; the master modport is the router plus the bus-side consumer.
interface pkt_to_msg_if #(
  parameter int BUS_DATA_WIDTH    = 32,
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int BUS_SEL_WIDTH     = 4,
  parameter int MAX_BURST_LENGHT  = 8
);
  localparam int FLIT_WIDTH = BUS_DATA_WIDTH + BUS_SEL_WIDTH + 2;
  localparam int LW         = $clog2(MAX_BURST_LENGHT) + 1;

  logic [FLIT_WIDTH-1:0]                      flit_i;
  logic                                       flit_valid_i;
  logic                                       flit_ready_o;
  logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] data_o;
  logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]  sel_o;
  logic [BUS_ADDRESS_WIDTH-1:0]               address_o;
  logic                                       WE_O;
  logic                                       reply_o;
  logic [LW-1:0]                              burst_len_o;
  logic                                       msg_valid_o;
  logic                                       msg_ready_i;
  logic                                       drop_o;

  modport slave (
    input  flit_i, flit_valid_i, msg_ready_i,
    output flit_ready_o, data_o, sel_o, address_o, WE_O, reply_o,
           burst_len_o, msg_valid_o, drop_o
  );

  modport master (
    output flit_i, flit_valid_i, msg_ready_i,
    input  flit_ready_o, data_o, sel_o, address_o, WE_O, reply_o,
           burst_len_o, msg_valid_o, drop_o
  );
endinterface

// File: rtl/pkt_to_msg.sv
// Reassembles router flits (head + data beats) into one parallel bus message and holds it
// until the consumer takes it; malformed or oversized packets are dropped with a drop_o pulse.
module pkt_to_msg #(
  parameter int BUS_DATA_WIDTH    = 32,
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int BUS_SEL_WIDTH     = 4,
  parameter int MAX_BURST_LENGHT  = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  pkt_to_msg_if.slave   bus,
  output logic [1:0]    state_dbg_o
);
  localparam int DW  = BUS_DATA_WIDTH;
  localparam int AW  = BUS_ADDRESS_WIDTH;
  localparam int SW  = BUS_SEL_WIDTH;
  localparam int MAX = MAX_BURST_LENGHT;
  localparam int FW  = DW + SW + 2;
  localparam int LW  = $clog2(MAX) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [MAX*DW-1:0]   data_q, data_d;
  logic [MAX*SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic                reply_q, reply_d;
  logic                drop_q, drop_d;
  logic [LW-1:0]       count_q, count_d;

  logic                f_head, f_tail, accept, load_hdr;
  logic [SW-1:0]       f_sel;
  logic [DW-1:0]       f_data;

  // Handshake: a flit moves only when flit_valid_i and flit_ready_o are high together.
  assign f_head = bus.flit_i[FW-1];
  assign f_tail = bus.flit_i[FW-2];
  assign f_sel  = bus.flit_i[DW +: SW];
  assign f_data = bus.flit_i[DW-1:0];

  assign bus.flit_ready_o = (state_q != HOLD) && !RST_I;
  assign accept           = bus.flit_valid_i && bus.flit_ready_o;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    reply_d  = reply_q;
    count_d  = count_q;
    drop_d   = 1'b0;
    load_hdr = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (f_head) load_hdr = 1'b1;
          else        drop_d   = 1'b1;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (f_head) begin
            // A new head aborts the packet in flight and starts over.
            drop_d   = 1'b1;
            load_hdr = 1'b1;
          end else if (count_q < LW'(MAX)) begin
            for (int k = 0; k < MAX; k++) begin
              if (count_q == LW'(k)) begin
                data_d[k*DW +: DW] = f_data;
                sel_d[k*SW +: SW]  = f_sel;
              end
            end
            count_d = count_q + LW'(1);
            if (f_tail) state_d = HOLD;
          end else begin
            drop_d  = 1'b1;
            state_d = f_tail ? IDLE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && f_tail) state_d = IDLE;
      end
      HOLD: begin
        if (bus.msg_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_hdr) begin
      addr_d  = f_data[AW-1:0];
      we_d    = f_sel[0];
      reply_d = f_sel[1];
      data_d  = '0;
      sel_d   = '0;
      count_d = '0;
      state_d = f_tail ? HOLD : COLLECT;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      reply_q <= 1'b0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      reply_q <= reply_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.data_o      = data_q;
  assign bus.sel_o       = sel_q;
  assign bus.address_o   = addr_q;
  assign bus.WE_O        = we_q;
  assign bus.reply_o     = reply_q;
  assign bus.burst_len_o = count_q;
  assign bus.msg_valid_o = (state_q == HOLD);
  assign bus.drop_o      = drop_q;
  assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_pkt_to_msg.sv
// Bench for pkt_to_msg: directed packets from the test plan, then random traffic,
// all checked against a packet-level reference model.
module tb_pkt_to_msg;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int MAX = 8;
  localparam int FW  = DW + SW + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  bit         rdy_rand = 1'b0;

  pkt_to_msg_if #(.BUS_DATA_WIDTH(DW), .BUS_ADDRESS_WIDTH(AW),
                  .BUS_SEL_WIDTH(SW), .MAX_BURST_LENGHT(MAX)) bus ();

  pkt_to_msg #(.BUS_DATA_WIDTH(DW), .BUS_ADDRESS_WIDTH(AW),
               .BUS_SEL_WIDTH(SW), .MAX_BURST_LENGHT(MAX)) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int drops_seen = 0;
  int valids_seen = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  bit              m_hold = 0, m_coll = 0, m_drain = 0, m_drop = 0, m_acc = 0;
  logic [AW-1:0]   m_addr = '0;
  bit              m_we = 0, m_reply = 0;
  logic [DW-1:0]   exp_q[$];
  logic [SW-1:0]   exp_sel_q[$];

  logic            f_hd, f_tl;
  logic [SW-1:0]   f_sel;
  logic [DW-1:0]   f_dat;
  assign f_hd  = bus.flit_i[FW-1];
  assign f_tl  = bus.flit_i[FW-2];
  assign f_sel = bus.flit_i[DW +: SW];
  assign f_dat = bus.flit_i[DW-1:0];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 0; m_coll <= 0; m_drain <= 0; m_drop <= 0; m_acc <= 0;
      exp_q.delete();
      exp_sel_q.delete();
    end else begin
      m_drop <= 0;
      m_acc  <= bus.flit_valid_i && !m_hold;
      if (m_hold) begin
        if (bus.msg_ready_i) m_hold <= 0;
      end else if (bus.flit_valid_i) begin
        if (m_drain) begin
          if (f_tl) m_drain <= 0;
        end else if (f_hd) begin
          if (m_coll) m_drop <= 1;
          m_addr  <= f_dat[AW-1:0];
          m_we    <= f_sel[0];
          m_reply <= f_sel[1];
          exp_q.delete();
          exp_sel_q.delete();
          m_coll  <= !f_tl;
          m_hold  <= f_tl;
        end else if (!m_coll) begin
          m_drop <= 1;
        end else if (exp_q.size() < MAX) begin
          exp_q.push_back(f_dat);
          exp_sel_q.push_back(f_sel);
          if (f_tl) begin
            m_coll <= 0;
            m_hold <= 1;
          end
        end else begin
          m_drop  <= 1;
          m_coll  <= 0;
          m_drain <= !f_tl;
        end
      end
    end
  end

  function automatic logic [MAX*DW-1:0] exp_data_vec();
    logic [MAX*DW-1:0] v = '0;
    for (int k = 0; k < exp_q.size(); k++) v[k*DW +: DW] = exp_q[k];
    return v;
  endfunction

  function automatic logic [MAX*SW-1:0] exp_sel_vec();
    logic [MAX*SW-1:0] v = '0;
    for (int k = 0; k < exp_sel_q.size(); k++) v[k*SW +: SW] = exp_sel_q[k];
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("flit_ready", 512'(bus.flit_ready_o), 512'(!m_hold && !rst));
    check("msg_valid", 512'(bus.msg_valid_o), 512'(m_hold));
    check("drop", 512'(bus.drop_o), 512'(m_drop));
    if (bus.drop_o) drops_seen <= drops_seen + 1;
    if (bus.msg_valid_o) valids_seen <= valids_seen + 1;
    if (m_hold) begin
      check("address", 512'(bus.address_o), 512'(m_addr));
      check("we", 512'(bus.WE_O), 512'(m_we));
      check("reply", 512'(bus.reply_o), 512'(m_reply));
      check("burst_len", 512'(bus.burst_len_o), 512'(exp_q.size()));
      check("data", 512'(bus.data_o), 512'(exp_data_vec()));
      check("sel", 512'(bus.sel_o), 512'(exp_sel_vec()));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [FW-1:0] mk_head(input logic [AW-1:0] a, input bit we, input bit rp, input bit tl);
    return {1'b1, tl, 2'b00, rp, we, a};
  endfunction

  function automatic logic [FW-1:0] mk_data(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit tl);
    return {1'b0, tl, s, d};
  endfunction

  task automatic send_flit(input logic [FW-1:0] f, output int waited);
    bus.flit_i       = f;
    bus.flit_valid_i = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
      if (rdy_rand) bus.msg_ready_i = ($urandom_range(0, 2) == 0);
    end while (!m_acc && waited < 64);
    check("accept_within_bound", 512'(m_acc), 512'(1'b1));
    bus.flit_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.flit_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rdy_rand) bus.msg_ready_i = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic take_msg();
    int n = 0;
    while (!m_hold && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    check("take_within_bound", 512'(m_hold), 512'(1'b1));
    bus.msg_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.msg_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int w, d0, v0, r, n;
    bit ab;
    bus.flit_i       = '0;
    bus.flit_valid_i = 1'b0;
    bus.msg_ready_i  = 1'b0;

    #1;
    check("rst_ready", 512'(bus.flit_ready_o), 512'(0));
    check("rst_valid", 512'(bus.msg_valid_o), 512'(0));
    check("rst_data", 512'(bus.data_o), 512'(0));
    check("rst_addr", 512'(bus.address_o), 512'(0));
    check("rst_len", 512'(bus.burst_len_o), 512'(0));
    #21 rst = 1'b0;
    #1 check("ready_after_release", 512'(bus.flit_ready_o), 512'(1));
    @(posedge clk); #1;

    // write packet
    d0 = drops_seen;
    send_flit(mk_head(32'h1000_0040, 1, 0, 0), w);
    send_flit(mk_data(32'hA, 4'hF, 0), w);
    send_flit(mk_data(32'hB, 4'h3, 0), w);
    send_flit(mk_data(32'hC, 4'h1, 1), w);
    check("wr_valid", 512'(bus.msg_valid_o), 512'(1));
    check("wr_len", 512'(bus.burst_len_o), 512'(3));
    check("wr_data", 512'(bus.data_o), 512'(256'h0000000C_0000000B_0000000A));
    check("wr_sel", 512'(bus.sel_o), 512'(32'h0000013F));
    check("wr_addr", 512'(bus.address_o), 512'(32'h1000_0040));
    check("wr_we", 512'(bus.WE_O), 512'(1));
    take_msg();
    check("wr_no_drop", 512'(drops_seen - d0), 512'(0));

    // header-only read request
    send_flit(mk_head(32'h2000_0000, 0, 1, 1), w);
    check("rd_valid", 512'(bus.msg_valid_o), 512'(1));
    check("rd_len", 512'(bus.burst_len_o), 512'(0));
    check("rd_data", 512'(bus.data_o), 512'(0));
    check("rd_reply", 512'(bus.reply_o), 512'(1));
    check("rd_we", 512'(bus.WE_O), 512'(0));

    // backpressure with the next head held valid
    bus.flit_i       = mk_head(32'h3000_0004, 1, 0, 0);
    bus.flit_valid_i = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_ready", 512'(bus.flit_ready_o), 512'(0));
      check("bp_addr", 512'(bus.address_o), 512'(32'h2000_0000));
    end
    bus.msg_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.msg_ready_i = 1'b0;
    check("bp_release_valid", 512'(bus.msg_valid_o), 512'(0));
    check("bp_release_ready", 512'(bus.flit_ready_o), 512'(1));
    send_flit(mk_head(32'h3000_0004, 1, 0, 0), w);
    check("bp_accept_delay", 512'(w), 512'(1));
    send_flit(mk_data(32'h55, 4'h5, 1), w);
    check("bp_len", 512'(bus.burst_len_o), 512'(1));
    check("bp_addr2", 512'(bus.address_o), 512'(32'h3000_0004));
    take_msg();

    // overflow
    d0 = drops_seen; v0 = valids_seen;
    send_flit(mk_head(32'h4000_0000, 1, 0, 0), w);
    for (int i = 1; i <= 10; i++) begin
      send_flit(mk_data(DW'(i), 4'hF, i == 10), w);
      if (i == 8) check("ovf_no_drop_8", 512'(bus.drop_o), 512'(0));
      if (i == 9) check("ovf_drop_9", 512'(bus.drop_o), 512'(1));
    end
    idle(2);
    check("ovf_one_drop", 512'(drops_seen - d0), 512'(1));
    check("ovf_no_valid", 512'(valids_seen - v0), 512'(0));
    check("ovf_idle_ready", 512'(bus.flit_ready_o), 512'(1));
    send_flit(mk_head(32'h5000_0008, 1, 0, 1), w);
    check("ovf_next_valid", 512'(bus.msg_valid_o), 512'(1));
    check("ovf_next_addr", 512'(bus.address_o), 512'(32'h5000_0008));
    take_msg();

    // malformed flits
    send_flit(mk_data(32'hDEAD, 4'h1, 1), w);
    check("mal_idle_drop", 512'(bus.drop_o), 512'(1));
    send_flit(mk_head(32'h6000_0000, 1, 0, 0), w);
    send_flit(mk_data(32'h11, 4'h1, 0), w);
    send_flit(mk_data(32'h22, 4'h2, 0), w);
    send_flit(mk_head(32'h7000_0010, 0, 0, 0), w);
    check("mal_abort_drop", 512'(bus.drop_o), 512'(1));
    send_flit(mk_data(32'h33, 4'h7, 1), w);
    check("mal_len", 512'(bus.burst_len_o), 512'(1));
    check("mal_data", 512'(bus.data_o), 512'(256'h33));
    check("mal_addr", 512'(bus.address_o), 512'(32'h7000_0010));
    take_msg();

    // reset mid-operation
    d0 = drops_seen;
    send_flit(mk_head(32'h8000_0000, 1, 0, 0), w);
    send_flit(mk_data(32'h1, 4'hF, 0), w);
    send_flit(mk_data(32'h2, 4'hF, 0), w);
    #2 rst = 1'b1;
    #1;
    check("mrst_data", 512'(bus.data_o), 512'(0));
    check("mrst_addr", 512'(bus.address_o), 512'(0));
    check("mrst_len", 512'(bus.burst_len_o), 512'(0));
    check("mrst_ready", 512'(bus.flit_ready_o), 512'(0));
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_no_drop", 512'(drops_seen - d0), 512'(0));
    send_flit(mk_head(32'h9000_0000, 1, 0, 0), w);
    for (int i = 1; i <= 4; i++) send_flit(mk_data(DW'(32'h100 + i), 4'hF, i == 4), w);
    check("mrst_len4", 512'(bus.burst_len_o), 512'(4));
    check("mrst_data4", 512'(bus.data_o), 512'(256'h00000104_00000103_00000102_00000101));
    take_msg();

    // random traffic
    rdy_rand = 1'b1;
    repeat (250) begin
      r = $urandom_range(0, 15);
      if (r == 0) begin
        send_flit({1'b0, 1'($urandom), 4'($urandom), 32'($urandom)}, w);
      end else begin
        n  = $urandom_range(0, 10);
        ab = ($urandom_range(0, 7) == 0);
        send_flit({1'b1, (n == 0) && !ab, 4'($urandom), 32'($urandom)}, w);
        for (int i = 0; i < n; i++) begin
          send_flit({1'b0, (i == n - 1) && !ab, 4'($urandom), 32'($urandom)}, w);
          idle($urandom_range(0, 1));
        end
      end
      idle($urandom_range(0, 2));
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
